// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the MEM/WB stream has priority, a late-result source is forced through after starvation.
// Optional macro WB_ARB_STATS_EN enables the saturating stall / late-commit statistics counters.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int RADDR_W      = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pipe_valid,
  input  logic [RADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]    pipe_data,
  output logic               pipe_ready,
  input  logic               late_valid,
  input  logic [RADDR_W-1:0] late_rd,
  input  logic [XLEN-1:0]    late_data,
  output logic               late_ready,
  output logic               late_killed,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic [31:0]        stat_stall_cnt,
  output logic [31:0]        stat_late_cnt,
  output logic               dbg_state,
  output logic [3:0]         dbg_starve_cnt
);

  // Handshake: a request transfers in any cycle where valid && ready; while
  // valid && !ready the requester holds rd/data stable. late_killed is only
  // meaningful together with late_ready and means "acked, write dropped".

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [3:0]         starve_cnt, starve_next;
  logic               wr_en;
  logic               wr_from_late;
  logic [RADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]    wr_data;
  logic               pipe_nz, late_nz, same_rd;

  assign pipe_nz = (pipe_rd != '0);
  assign late_nz = (late_rd != '0);
  assign same_rd = (pipe_rd == late_rd);

  always_comb begin
    state_next   = state;
    starve_next  = starve_cnt;
    pipe_ready   = 1'b1;
    late_ready   = 1'b0;
    late_killed  = 1'b0;
    wr_en        = 1'b0;
    wr_from_late = 1'b0;
    wr_addr      = pipe_rd;
    wr_data      = pipe_data;
    case (state)
      NORMAL: begin
        late_ready  = late_valid && (!pipe_valid || !pipe_nz || same_rd);
        // Same non-zero destination: the younger pipeline write supersedes the late one.
        late_killed = late_valid && pipe_valid && pipe_nz && same_rd;
        if (pipe_valid && pipe_nz) begin
          wr_en = 1'b1;
        end else if (late_ready && late_nz) begin
          wr_en        = 1'b1;
          wr_from_late = 1'b1;
          wr_addr      = late_rd;
          wr_data      = late_data;
        end
        if (late_valid && !late_ready) begin
          starve_next = starve_cnt + 4'd1;
          if (starve_next == 4'(STARVE_LIMIT)) begin
            state_next = FORCE;
          end
        end else begin
          starve_next = 4'd0;
        end
      end
      FORCE: begin
        // Pipeline stalls; a same-rd pipeline write lands the cycle after, keeping program order.
        pipe_ready = 1'b0;
        late_ready = late_valid;
        if (late_valid && late_nz) begin
          wr_en        = 1'b1;
          wr_from_late = 1'b1;
          wr_addr      = late_rd;
          wr_data      = late_data;
        end
        state_next  = NORMAL;
        starve_next = 4'd0;
      end
      default: begin
        state_next  = NORMAL;
        starve_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
    end
  end

  assign fwd_valid      = rf_we;
  assign fwd_rd         = rf_waddr;
  assign fwd_data       = rf_wdata;
  assign dbg_state      = (state == FORCE);
  assign dbg_starve_cnt = starve_cnt;

`ifdef WB_ARB_STATS_EN
  logic [31:0] stall_q, late_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      late_q  <= '0;
    end else begin
      if (pipe_valid && !pipe_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (wr_en && wr_from_late && (late_q != '1)) begin
        late_q <= late_q + 32'd1;
      end
    end
  end

  assign stat_stall_cnt = stall_q;
  assign stat_late_cnt  = late_q;
`else
  assign stat_stall_cnt = 32'd0;
  assign stat_late_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a per-cycle reference model with an expected-write queue,
// plus literal checks for each scenario.
module tb_wb_port_arbiter;
  localparam int XLEN  = 64;
  localparam int RW    = 6;
  localparam int LIMIT = 4;
  localparam int EW    = 1 + RW + XLEN;

  logic            clk = 1'b0;
  logic            reset;
  logic            pipe_valid, late_valid;
  logic [RW-1:0]   pipe_rd, late_rd;
  logic [XLEN-1:0] pipe_data, late_data;
  logic            pipe_ready, late_ready, late_killed;
  logic            rf_we, fwd_valid;
  logic [RW-1:0]   rf_waddr, fwd_rd;
  logic [XLEN-1:0] rf_wdata, fwd_data;
  logic [31:0]     stat_stall_cnt, stat_late_cnt;
  logic            dbg_state;
  logic [3:0]      dbg_starve_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_port_arbiter #(.XLEN(XLEN), .RADDR_W(RW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .late_valid(late_valid), .late_rd(late_rd), .late_data(late_data),
    .late_ready(late_ready), .late_killed(late_killed),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .stat_stall_cnt(stat_stall_cnt), .stat_late_cnt(stat_late_cnt),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic pv, input logic [RW-1:0] prd, input logic [XLEN-1:0] pd,
                       input logic lv, input logic [RW-1:0] lrd, input logic [XLEN-1:0] ld);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    late_valid = lv; late_rd = lrd; late_data = ld;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: reference model, one expected write word {we, rd, data} per cycle
  logic [EW-1:0] exp_q[$];
  bit            m_force;
  int            m_starve;
  int            m_stall, m_late;

  always @(negedge clk) begin
    logic [EW-1:0] e, nxt;
    logic e_pr, e_lr, e_lk, late_commit;
    if (!reset) begin
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_waddr", rf_waddr, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_fwd_valid", fwd_valid, 0);
      check("rst_pipe_ready", pipe_ready, 1);
      m_force = 0; m_starve = 0; m_stall = 0; m_late = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("rf_we", rf_we, e[EW-1]);
      check("fwd_valid", fwd_valid, e[EW-1]);
      if (e[EW-1]) begin
        check("rf_waddr", rf_waddr, e[EW-2 -: RW]);
        check("rf_wdata", rf_wdata, e[XLEN-1:0]);
        check("fwd_rd", fwd_rd, e[EW-2 -: RW]);
        check("fwd_data", fwd_data, e[XLEN-1:0]);
      end
`ifdef WB_ARB_STATS_EN
      check("stat_stall", stat_stall_cnt, m_stall);
      check("stat_late", stat_late_cnt, m_late);
`else
      check("stat_stall", stat_stall_cnt, 0);
      check("stat_late", stat_late_cnt, 0);
`endif
      // Expected handshakes and the single write that survives this cycle.
      nxt = '0;
      late_commit = 0;
      if (m_force) begin
        e_pr = 0;
        e_lr = late_valid;
        e_lk = 0;
        if (late_valid && late_rd != 0) begin
          nxt = {1'b1, late_rd, late_data};
          late_commit = 1;
        end
      end else begin
        e_pr = 1;
        e_lr = late_valid && (!pipe_valid || pipe_rd == 0 || pipe_rd == late_rd);
        e_lk = late_valid && pipe_valid && pipe_rd != 0 && pipe_rd == late_rd;
        if (pipe_valid && pipe_rd != 0) nxt = {1'b1, pipe_rd, pipe_data};
        else if (e_lr && late_rd != 0) begin
          nxt = {1'b1, late_rd, late_data};
          late_commit = 1;
        end
      end
      check("pipe_ready", pipe_ready, e_pr);
      check("late_ready", late_ready, e_lr);
      check("late_killed", late_killed, e_lk);
      exp_q.push_back(nxt);
      if (pipe_valid && !e_pr) m_stall++;
      if (late_commit) m_late++;
      if (m_force) begin
        m_force = 0; m_starve = 0;
      end else if (late_valid && !e_lr) begin
        m_starve++;
        if (m_starve == LIMIT) m_force = 1;
      end else begin
        m_starve = 0;
      end
    end
  end

  // directed mixed vectors: {pv, prd, lv, lrd}
  logic [RW-1:0] vec_prd[6] = '{6'd4, 6'd4, 6'd0, 6'd8, 6'd2, 6'd0};
  logic [RW-1:0] vec_lrd[6] = '{6'd4, 6'd0, 6'd0, 6'd9, 6'd2, 6'd11};
  logic          vec_pv[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic          vec_lv[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    reset = 1'b0;
    idle();
    step(); step();
    check("lit_reset_we", rf_we, 0);
    check("lit_reset_pipe_ready", pipe_ready, 1);
    reset = 1'b1;
    step();

    // pipeline only
    drive(1, 6'd5, 64'h1234, 0, '0, '0);
    #2 check("lit_pipe_ready", pipe_ready, 1);
    step(); idle();
    check("lit_pipe_we", rf_we, 1);
    check("lit_pipe_waddr", rf_waddr, 5);
    check("lit_pipe_wdata", rf_wdata, 64'h1234);
    check("lit_pipe_fwd", fwd_data, 64'h1234);
    step();
    check("lit_pipe_one_cycle", rf_we, 0);

    // late only
    drive(0, '0, '0, 1, 6'd10, 64'hDEAD);
    #2 check("lit_late_ready", late_ready, 1);
    step(); idle();
    check("lit_late_waddr", rf_waddr, 10);
    check("lit_late_wdata", rf_wdata, 64'hDEAD);
    step();

    // same-rd collision
    drive(1, 6'd7, 64'hA, 1, 6'd7, 64'hB);
    #2 check("lit_coll_late_ready", late_ready, 1);
    check("lit_coll_killed", late_killed, 1);
    step(); idle();
    check("lit_coll_waddr", rf_waddr, 7);
    check("lit_coll_wdata", rf_wdata, 64'hA);
    step();
    check("lit_coll_single", rf_we, 0);

    // starvation and forced grant
    drive(1, 6'd3, 64'h33, 1, 6'd9, 64'h99);
    for (int i = 0; i < LIMIT; i++) begin
      #2 check("lit_starve_refused", late_ready, 0);
      step();
    end
    #2 check("lit_force_pipe_ready", pipe_ready, 0);
    check("lit_force_late_ready", late_ready, 1);
    check("lit_force_killed", late_killed, 0);
    check("lit_force_state", dbg_state, 1);
    step();
    drive(1, 6'd3, 64'h33, 0, '0, '0);
    check("lit_force_waddr", rf_waddr, 9);
    check("lit_force_wdata", rf_wdata, 64'h99);
    #2 check("lit_normal_pipe_ready", pipe_ready, 1);
    step(); idle();
    check("lit_stalled_pipe_waddr", rf_waddr, 3);
`ifdef WB_ARB_STATS_EN
    check("lit_stat_stall", stat_stall_cnt, 1);
    check("lit_stat_late", stat_late_cnt, 2);
`else
    check("lit_stat_stall", stat_stall_cnt, 0);
    check("lit_stat_late", stat_late_cnt, 0);
`endif
    step();

    // x0 handling
    drive(1, 6'd0, 64'h5, 1, 6'd12, 64'hC);
    #2 check("lit_x0_pipe_ready", pipe_ready, 1);
    check("lit_x0_late_ready", late_ready, 1);
    step();
    drive(1, 6'd0, 64'h6, 0, '0, '0);
    check("lit_x0_waddr", rf_waddr, 12);
    check("lit_x0_wdata", rf_wdata, 64'hC);
    step(); idle();
    check("lit_x0_alone_we", rf_we, 0);
    step();

    // mixed directed vectors, checked by the model only
    for (int i = 0; i < 6; i++) begin
      drive(vec_pv[i], vec_prd[i], 64'h100 + i, vec_lv[i], vec_lrd[i], 64'h200 + i);
      step();
    end
    idle();
    step();

    // reset asserted mid-FORCE
    drive(1, 6'd3, 64'h44, 1, 6'd9, 64'h55);
    for (int i = 0; i < LIMIT; i++) step();
    check("lit_rst_in_force", dbg_state, 1);
    reset = 1'b0;
    #1 check("lit_rst_we_now", rf_we, 0);
    idle();
    step(); step();
    reset = 1'b1;
    #2 check("lit_rst_pipe_ready", pipe_ready, 1);
    check("lit_rst_starve", dbg_starve_cnt, 0);
    check("lit_rst_state", dbg_state, 0);
    step();
    drive(1, 6'd1, 64'h77, 0, '0, '0);
    step(); idle();
    check("lit_after_rst_waddr", rf_waddr, 1);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port at the back of the pipeline.
- Shares it between the in-order MEM/WB writeback stream and a late-result source (ecall return values, future multi-cycle units).
- Pipeline has priority; a starvation counter forces the late source through.
- Registers the winning write and republishes it as a forwarding bus for EX.

Parameters:
- XLEN, 64, data width.
- RADDR_W, 6, destination register index width.
- STARVE_LIMIT, 4, consecutive refused late-valid cycles before a forced grant; legal 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pipe_valid  in  1  MEM/WB has a writeback this cycle
- pipe_rd  in  RADDR_W  pipeline destination
- pipe_data  in  XLEN  pipeline result (ALU or loaded data, already selected)
- pipe_ready  out  1  pipeline write accepted; 0 stalls MEM/WB
- late_valid  in  1  late source requests a write
- late_rd  in  RADDR_W  late destination
- late_data  in  XLEN  late result
- late_ready  out  1  late write accepted or killed
- late_killed  out  1  with late_ready: write dropped as superseded
- rf_we  out  1  register-file write enable
- rf_waddr  out  RADDR_W  write index
- rf_wdata  out  XLEN  write data
- fwd_valid  out  1  forwarding bus valid (equals rf_we)
- fwd_rd  out  RADDR_W  forwarding index
- fwd_data  out  XLEN  forwarding data
- stat_stall_cnt  out  32  pipeline stall cycles
- stat_late_cnt  out  32  late writes committed

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0; fwd_* mirror these.
  - state=NORMAL, starve_cnt=0, stats=0.
  - Combinational outputs follow NORMAL rules.
- Handshake:
  - A transfer occurs in a cycle with valid&&ready.
  - Requesters hold rd/data stable while valid&&!ready.
- Latency: a write accepted in cycle N drives rf_we/rf_waddr/rf_wdata/fwd_* during cycle N+1, for exactly one cycle unless another write follows.
- x0 rule:
  - A request with rd==0 is accepted (ready=1) but never produces rf_we.
  - It does not occupy the port, so the other requester may be granted in the same cycle.
- FSM state NORMAL:
  - pipe_ready=1 always.
  - late_ready=1 when late_valid and (!pipe_valid || pipe_rd==0 || pipe_rd==late_rd).
  - pipe_valid && late_valid && pipe_rd==late_rd!=0: the pipeline write (younger) is committed; late is acked with late_killed=1 and no write.
  - Late-only or x0-pipe cases: the late write is committed.
  - starve_cnt increments each cycle late_valid && !late_ready; it clears on any late handshake or when !late_valid.
  - When starve_cnt reaches STARVE_LIMIT, go to FORCE next cycle.
- FSM state FORCE:
  - pipe_ready=0; late_ready=late_valid; late_killed=0; the late write is committed.
  - On the late handshake: go to NORMAL, starve_cnt=0.
  - If late_valid falls (protocol violation): go to NORMAL with no write.
  - A stalled pipeline with the same rd writes the following cycle, so program order is preserved.
- Write data width: rf_wdata is XLEN, passed through unmodified; no sign or zero manipulation.
- Reset asserted mid-FORCE: the forced grant is abandoned and no write is issued.
- late_killed=0 whenever late_ready=0.

Optional Feature:
- WB_ARB_STATS_EN, when defined:
  - stat_stall_cnt increments each cycle pipe_valid && !pipe_ready.
  - stat_late_cnt increments on each committed (not killed) late write with rd!=0.
  - Both saturate at 2^32-1.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Pipeline only: pipe_valid=1, rd=5, data=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, fwd_* equal; pipe_ready stays 1.
- Late only: late_valid=1, rd=10, data=0xDEAD -> late_ready=1 same cycle; next cycle rf_waddr=10, rf_wdata=0xDEAD.
- Same rd collision: pipe rd=7 data=0xA and late rd=7 data=0xB in one cycle -> late_ready=1, late_killed=1; next cycle a single write of x7=0xA.
- Starvation, STARVE_LIMIT=4: pipe_valid=1 continuously (rd=3), late_valid=1 (rd=9) -> late refused 4 cycles, 5th cycle pipe_ready=0 and late_ready=1, x9 written; NORMAL resumes; stat_late_cnt=1 and stat_stall_cnt=1 with the macro.
- x0 handling: pipe rd=0 and late rd=12 together -> both ready=1; only x12 written; rd=0 alone -> rf_we stays 0.
- Reset mid-FORCE: drive reset=0 while in FORCE -> rf_we=0 immediately; after release pipe_ready=1 and starve_cnt=0.
